// File: rtl/vga_bram_reader.sv
// VGA read-side controller: raster counters drive sequential frame-BRAM reads,
// and the returned RGB444 word is registered onto the pins with syncs delayed to match.
module vga_bram_reader #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 12
) (
   input  logic                  p_clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic                  bram_read_enable,
   output logic [ADDR_WIDTH-1:0] bram_address,
   input  logic [DATA_WIDTH-1:0] bram_data,
   output logic [3:0]            vga_r,
   output logic [3:0]            vga_g,
   output logic [3:0]            vga_b,
   output logic                  vga_hsync,
   output logic                  vga_vsync,
   output logic                  frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

   logic [HW-1:0]         h_cnt_q, h_cnt_d;
   logic [VW-1:0]         v_cnt_q, v_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  ren_q, ren_d;
   logic                  active1_q, active1_d;
   logic                  hs1_q, hs1_d;
   logic                  vs1_q, vs1_d;
   logic                  first1_q, first1_d;
   logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;
   logic                  fs_q, fs_d;

   logic active0, hs0, vs0, h_last, v_last;

   always_comb begin
      active0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs0     = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
      vs0     = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
      h_last  = (h_cnt_q == H_LAST);
      v_last  = (v_cnt_q == V_LAST);

      h_cnt_d   = '0;
      v_cnt_d   = '0;
      addr_d    = '0;
      ren_d     = 1'b0;
      active1_d = 1'b0;
      hs1_d     = 1'b1;
      vs1_d     = 1'b1;
      first1_d  = 1'b0;
      rgb_d     = '0;
      hsync_d   = 1'b1;
      vsync_d   = 1'b1;
      fs_d      = 1'b0;

      if (enable) begin
         h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
         v_cnt_d = !h_last ? v_cnt_q : (v_last ? '0 : v_cnt_q + 1'b1);

         // Address walks with the raster; it stops at the last pixel and restarts only at frame wrap.
         addr_d = addr_q;
         if (h_last && v_last)
            addr_d = '0;
         else if (active0 && (addr_q != ADDR_LAST))
            addr_d = addr_q + 1'b1;

         // Strobe is evaluated on the next counter value so it lines up with addr_q.
         ren_d = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);

         active1_d = active0;
         hs1_d     = hs0;
         vs1_d     = vs0;
         first1_d  = (h_cnt_q == '0) && (v_cnt_q == '0);

         rgb_d   = active1_q ? bram_data : '0;
         hsync_d = hs1_q;
         vsync_d = vs1_q;
         fs_d    = first1_q;
      end
   end

   always_ff @(posedge p_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         addr_q    <= '0;
         ren_q     <= 1'b0;
         active1_q <= 1'b0;
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
         first1_q  <= 1'b0;
         rgb_q     <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         fs_q      <= 1'b0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         addr_q    <= addr_d;
         ren_q     <= ren_d;
         active1_q <= active1_d;
         hs1_q     <= hs1_d;
         vs1_q     <= vs1_d;
         first1_q  <= first1_d;
         rgb_q     <= rgb_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         fs_q      <= fs_d;
      end
   end

   assign bram_read_enable = ren_q;
   assign bram_address     = addr_q;
   assign vga_r            = rgb_q[11:8];
   assign vga_g            = rgb_q[7:4];
   assign vga_b            = rgb_q[3:0];
   assign vga_hsync        = hsync_q;
   assign vga_vsync        = vsync_q;
   assign frame_start      = fs_q;

endmodule

// File: tb/tb_vga_bram_reader.sv
// Directed bench: a full-size 640x480 instance for line-level behaviour and a
// tiny-raster instance (16x8 total) so frame wrap and vsync fit in a short run.
module tb_vga_bram_reader;

   logic        p_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;

   logic        ren_a, hs_a, vs_a, fs_a;
   logic [18:0] addr_a;
   logic [11:0] data_a = '0;
   logic [3:0]  r_a, g_a, b_a;

   logic        ren_b, hs_b, vs_b, fs_b;
   logic [18:0] addr_b;
   logic [11:0] data_b = '0;
   logic [3:0]  r_b, g_b, b_b;

   always #5 p_clk = ~p_clk;

   vga_bram_reader dut_a (
      .p_clk(p_clk), .rst_n(rst_n), .enable(enable),
      .bram_read_enable(ren_a), .bram_address(addr_a), .bram_data(data_a),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
      .vga_hsync(hs_a), .vga_vsync(vs_a), .frame_start(fs_a)
   );

   vga_bram_reader #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_b (
      .p_clk(p_clk), .rst_n(rst_n), .enable(enable),
      .bram_read_enable(ren_b), .bram_address(addr_b), .bram_data(data_b),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
      .vga_hsync(hs_b), .vga_vsync(vs_b), .frame_start(fs_b)
   );

   // BRAM models with mem[i] = i[11:0], one-cycle synchronous read
   always @(posedge p_clk) begin
      data_a <= addr_a[11:0];
      data_b <= addr_b[11:0];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
         $display("[TB] cyc %0d %s = 0x%0h ok", cyc, tag, obs);
      else begin
         fails++;
         $error("FAIL %s at cyc %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic go(input int target);
      while (cyc < target) begin
         @(posedge p_clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      repeat (3) @(posedge p_clk);
      #1;
      check("rst_rgb",   {20'd0, r_a, g_a, b_a}, 32'h0);
      check("rst_hsync", {31'd0, hs_a}, 32'd1);
      check("rst_vsync", {31'd0, vs_a}, 32'd1);
      check("rst_addr",  {13'd0, addr_a}, 32'd0);
      check("rst_fs",    {31'd0, fs_a}, 32'd0);
      check("rst_ren",   {31'd0, ren_a}, 32'd0);

      @(negedge p_clk);
      rst_n = 1'b1;
      cyc = 0;

      go(1);
      check("addr_first_adv", {13'd0, addr_a}, 32'd1);
      check("ren_first_adv",  {31'd0, ren_a}, 32'd1);
      go(2);
      check("fs_first",     {31'd0, fs_a}, 32'd1);
      check("rgb_px0",      {20'd0, r_a, g_a, b_a}, 32'h000);
      check("fs_first_b",   {31'd0, fs_b}, 32'd1);
      go(3);
      check("fs_drop",      {31'd0, fs_a}, 32'd0);
      check("rgb_px1",      {20'd0, r_a, g_a, b_a}, 32'h001);

      go(12);
      check("b_hs_fall",    {31'd0, hs_b}, 32'd0);
      go(14);
      check("b_hs_last",    {31'd0, hs_b}, 32'd0);
      go(15);
      check("b_hs_rise",    {31'd0, hs_b}, 32'd1);
      go(18);
      check("b_rgb_line1",  {20'd0, r_b, g_b, b_b}, 32'h008);
      go(27);
      check("b_hs_pre2",    {31'd0, hs_b}, 32'd1);
      go(28);
      check("b_hs_fall2",   {31'd0, hs_b}, 32'd0);

      go(55);
      check("b_addr_max",   {13'd0, addr_b}, 32'd31);
      go(56);
      check("b_addr_hold",  {13'd0, addr_b}, 32'd31);
      go(81);
      check("b_vs_pre",     {31'd0, vs_b}, 32'd1);
      go(82);
      check("b_vs_fall",    {31'd0, vs_b}, 32'd0);
      go(113);
      check("b_vs_last",    {31'd0, vs_b}, 32'd0);
      go(114);
      check("b_vs_rise",    {31'd0, vs_b}, 32'd1);
      go(127);
      check("b_addr_endfr", {13'd0, addr_b}, 32'd31);
      go(128);
      check("b_addr_wrap",  {13'd0, addr_b}, 32'd0);
      go(129);
      check("b_fs_pre",     {31'd0, fs_b}, 32'd0);
      go(130);
      check("b_fs_frame2",  {31'd0, fs_b}, 32'd1);
      go(131);
      check("b_fs_post",    {31'd0, fs_b}, 32'd0);
      go(209);
      check("b_vs_pre2",    {31'd0, vs_b}, 32'd1);
      go(210);
      check("b_vs_fall2",   {31'd0, vs_b}, 32'd0);

      go(302);
      check("rgb_px300",    {20'd0, r_a, g_a, b_a}, 32'h12C);
      go(641);
      check("rgb_px639",    {20'd0, r_a, g_a, b_a}, 32'h27F);
      go(642);
      check("rgb_blank",    {20'd0, r_a, g_a, b_a}, 32'h000);
      check("addr_hblank",  {13'd0, addr_a}, 32'd640);
      go(657);
      check("hs_pre",       {31'd0, hs_a}, 32'd1);
      go(658);
      check("hs_fall",      {31'd0, hs_a}, 32'd0);
      go(753);
      check("hs_last",      {31'd0, hs_a}, 32'd0);
      go(754);
      check("hs_rise",      {31'd0, hs_a}, 32'd1);
      go(800);
      check("addr_line1",   {13'd0, addr_a}, 32'd640);
      check("ren_line1",    {31'd0, ren_a}, 32'd1);
      go(802);
      check("rgb_line1_px0", {20'd0, r_a, g_a, b_a}, 32'h280);
      check("fs_mid",       {31'd0, fs_a}, 32'd0);

      go(900);
      check("addr_100_1",   {13'd0, addr_a}, 32'd740);
      enable = 1'b0;
      go(901);
      check("dis_rgb",      {20'd0, r_a, g_a, b_a}, 32'h000);
      check("dis_hs",       {31'd0, hs_a}, 32'd1);
      check("dis_fs",       {31'd0, fs_a}, 32'd0);
      check("dis_addr",     {13'd0, addr_a}, 32'd0);
      check("dis_ren",      {31'd0, ren_a}, 32'd0);
      go(905);
      check("dis_hold_rgb", {20'd0, r_a, g_a, b_a}, 32'h000);
      enable = 1'b1;
      go(906);
      check("reen_fs0",     {31'd0, fs_a}, 32'd0);
      check("reen_addr",    {13'd0, addr_a}, 32'd1);
      go(907);
      check("reen_fs",      {31'd0, fs_a}, 32'd1);
      check("reen_rgb0",    {20'd0, r_a, g_a, b_a}, 32'h000);
      go(908);
      check("reen_rgb1",    {20'd0, r_a, g_a, b_a}, 32'h001);
      go(950);
      check("reen_rgb43",   {20'd0, r_a, g_a, b_a}, 32'h02B);

      #2;
      rst_n = 1'b0;
      #1;
      check("async_rgb",    {20'd0, r_a, g_a, b_a}, 32'h000);
      check("async_addr",   {13'd0, addr_a}, 32'd0);
      check("async_ren",    {31'd0, ren_a}, 32'd0);
      check("async_hs",     {31'd0, hs_a}, 32'd1);
      check("async_vs",     {31'd0, vs_a}, 32'd1);
      check("async_fs",     {31'd0, fs_a}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
